// File: rtl/pcm_mixer.sv
// pcm_mixer: CHANNELS-input volume mixer on one time-multiplexed MAC, saturating PCM
// output and first-order sigma-delta DAC. Optional tape monitor term: MIXER_TAPE_EN.
module pcm_mixer #(
  parameter int CHANNELS = 3,
  parameter int DW       = 8,
  parameter int VW       = 4,
  parameter int OW       = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [CHANNELS*DW-1:0] ch,
  input  logic [CHANNELS*VW-1:0] vol,
  input  logic                   mute,
  input  logic                   tape,
  output logic [OW-1:0]          pcm,
  output logic                   valid,
  output logic                   overrun,
  output logic                   sound
);
  localparam int AW = DW + $clog2(CHANNELS + 1) + 1;
  localparam int TW = ((AW > OW) ? AW : OW) + 1;
  localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = DW + VW + 1;
  localparam logic [KW-1:0] KLAST   = KW'(CHANNELS - 1);
  localparam logic [TW-1:0] PCM_MAX = TW'((1 << OW) - 1);

  typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

  state_t                 state;
  logic [CHANNELS*DW-1:0] ch_q;
  logic [CHANNELS*VW-1:0] vol_q;
  logic [KW-1:0]          k;
  logic [AW-1:0]          acc;
  logic [OW:0]            sd;

  logic [DW-1:0] samp;
  logic [VW-1:0] gain;
  logic [PW-1:0] prod;
  logic [AW-1:0] term;
  logic [TW-1:0] total;
  logic [OW-1:0] sat;

  // (vol+1) makes full-scale volume exact unity gain after the >>VW
  always_comb begin
    samp = ch_q[k*DW +: DW];
    gain = vol_q[k*VW +: VW];
    prod = PW'(samp) * (PW'(gain) + PW'(1));
    term = AW'(prod >> VW);
`ifdef MIXER_TAPE_EN
    total = TW'(acc) + (tape ? TW'(1 << (OW - 3)) : '0);
`else
    total = TW'(acc);
`endif
    sat = (total > PCM_MAX) ? '1 : total[OW-1:0];
  end

`ifndef MIXER_TAPE_EN
  logic unused_tape;
  assign unused_tape = tape;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ch_q    <= '0;
      vol_q   <= '0;
      k       <= '0;
      acc     <= '0;
      pcm     <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (ce) begin
          ch_q  <= ch;
          vol_q <= vol;
          acc   <= '0;
          k     <= '0;
          state <= SUM;
        end
        SUM: begin
          if (ce) overrun <= 1'b1;
          acc <= acc + term;
          if (k == KLAST) state <= OUT;
          else            k     <= k + KW'(1);
        end
        OUT: begin
          if (ce) overrun <= 1'b1;
          pcm   <= mute ? '0 : sat;
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // carry out of the OW-bit phase accumulator is the DAC bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sd <= '0;
    else       sd <= {1'b0, sd[OW-1:0]} + {1'b0, pcm};
  end

  assign sound = sd[OW];
endmodule

// File: doc/pcm_mixer.md
# pcm_mixer

Parametrised audio mixer and 1-bit DAC for the machine top level. It replaces the fixed three-input sum feeding the sigma-delta DAC. On each sample strobe it latches CHANNELS unsigned samples and applies a per-channel volume using one time-multiplexed multiply-accumulate. It then saturates the result to the PCM width and drives both the parallel `pcm` bus and a first-order sigma-delta `sound` bit.

## Interface
Parameters:
- CHANNELS, 3: number of input channels (1..8).
- DW, 8: sample width per channel, unsigned.
- VW, 4: volume width per channel.
- OW, 10: output PCM width; also the sigma-delta resolution.

Ports:
- clock  in  1  system clock; every register uses its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ce  in  1  sample strobe, one clock wide (the CPU-rate enable at top level).
- ch  in  CHANNELS*DW  packed samples; channel k is ch[k*DW +: DW].
- vol  in  CHANNELS*VW  packed volumes; channel k is vol[k*VW +: VW].
- mute  in  1  forces the next produced sample to 0.
- tape  in  1  tape monitor bit; used only with MIXER_TAPE_EN.
- pcm  out  OW  mixed, saturated sample.
- valid  out  1  one-clock pulse when `pcm` updates.
- overrun  out  1  sticky flag: a strobe arrived while busy.
- sound  out  1  sigma-delta bitstream.

## Operation
- The FSM has three states: IDLE, SUM, OUT.
- IDLE:
  - On `ce`, latch `ch` and `vol` into shadow registers.
  - Clear the accumulator, set index k to 0, go to SUM.
  - Input changes after the latch do not affect the current sample.
- SUM, one channel per clock:
  - term = (sample_k * (vol_k + 1)) >> VW. A full-scale volume gives unity gain; volume 0 gives sample/2^VW.
  - term is DW bits wide. The accumulator is DW + clog2(CHANNELS+1) + 1 bits wide, so it never wraps.
  - acc += term. If k == CHANNELS-1, go to OUT; otherwise k++.
- OUT:
  - Form total = acc plus the tape term (see Configuration).
  - pcm <= mute ? 0 : min(total, 2^OW - 1).
  - Assert `valid` for this one clock, then go to IDLE.
- overrun:
  - `ce` seen in SUM or OUT is dropped and sets `overrun`.
  - The flag clears only on reset.
  - The sample in progress completes unaffected.
- Sigma-delta:
  - Every clock: sd <= {1'b0, sd[OW-1:0]} + pcm, with sd being OW+1 bits wide.
  - sound = sd[OW], registered.
  - The ones density equals pcm / 2^OW.
- Reset mid-operation: asserting reset in any state aborts the sample. State, accumulator and all outputs return to reset values; no `valid` is emitted.

## Timing
- Reset values: pcm=0, valid=0, overrun=0, sound=0, sd=0, state IDLE, k=0.
- Latency:
  - `ce` is sampled at edge 0.
  - `pcm` takes its new value and `valid` rises at edge CHANNELS+1.
  - `valid` falls at edge CHANNELS+2.
- A `ce` is accepted again from edge CHANNELS+2 onward. The minimum strobe spacing is therefore CHANNELS+2 clocks (5 for the default).
- `pcm` holds its value between `valid` pulses.
- `mute` and `tape` are sampled in OUT only.
- The sigma-delta path sees a new `pcm` one clock after `valid`. `sound` lags `sd` by zero clocks because it is the register MSB.
- Simultaneous `ce` and reset: reset wins.

## Configuration
- MIXER_TAPE_EN defined:
  - In OUT, when tape=1, the term 2^(OW-3) is added before saturation (128 for OW=10).
  - `mute` still forces 0.
- MIXER_TAPE_EN undefined:
  - `tape` is ignored; no logic is generated for it.
  - total = acc.

## Test plan
- Reset: assert reset at a random point during SUM -> pcm=0, valid=0, overrun=0, sound=0 immediately. The FSM is in IDLE after release, and no `valid` pulse follows.
- Unity mix (defaults): ch = {0x40,0x40,0x40}, vol all 0xF, pulse ce -> pcm=0x0C0 four clocks later, valid high exactly one clock.
- Volume scaling: ch = {0xFF,0xFF,0xFF}, vol all 0x7 -> term 127 each, pcm=381 (0x17D).
- Saturation (CHANNELS=5, OW=10): all samples 0xFF, vol 0xF -> raw 1275, pcm=1023. With mute=1 the next sample gives pcm=0.
- Overrun: pulse ce, then pulse ce again 2 clocks later -> first sample completes with its correct value, overrun=1 and stays 1. Only one valid pulse occurs.
- Sigma-delta and tape:
  - Hold pcm=256 (OW=10) -> exactly 256 ones in any aligned 1024-clock window on `sound`.
  - With MIXER_TAPE_EN, all inputs 0 and tape=1 -> pcm=128.
  - Without MIXER_TAPE_EN, the same stimulus gives pcm=0.
